// File: rtl/ram2_ctrl_pkg.sv
// Shared types and constants for the RAM2 SRAM controller.
package ram2_ctrl_pkg;

  localparam int unsigned DATA_BUS_W      = 16;
  localparam int unsigned INST_BUS_W      = 16;
  localparam int unsigned DATA_ADDR_BUS_W = 16;

  localparam logic [INST_BUS_W-1:0] NOP_INST_DEF = 16'h0800;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_SETUP  = 3'd1,
    ST_RD_SAMPLE = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_PULSE  = 3'd4,
    ST_WR_HOLD   = 3'd5
  } state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // SRAM control strobes, all active low.
  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
  } ram_ctl_t;

  localparam ram_ctl_t RAM_CHIP_DISABLE = ram_ctl_t'(3'b111);
  localparam ram_ctl_t RAM_READ_ENABLE  = ram_ctl_t'(3'b001);
  localparam ram_ctl_t RAM_WRITE_SETUP  = ram_ctl_t'(3'b011);
  localparam ram_ctl_t RAM_WRITE_ENABLE = ram_ctl_t'(3'b010);

endpackage

// File: rtl/ram2_ctrl.sv
// Multi-cycle controller sharing one async 16-bit SRAM between IF fetch and MEM data ports.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int unsigned             SRAM_AW    = 18,
  parameter logic [INST_BUS_W-1:0]   NOP_INST   = NOP_INST_DEF,
  parameter bit                      WR_HOLD_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_req,
  input  logic [DATA_ADDR_BUS_W-1:0] pc,
  output logic [INST_BUS_W-1:0]      inst,
  output logic                       if_ready,
  input  logic                       mem_ce,
  input  logic                       mem_re,
  input  logic                       mem_we,
  input  logic [DATA_ADDR_BUS_W-1:0] mem_addr_i,
  input  logic [DATA_BUS_W-1:0]      mem_data_i,
  output logic [DATA_BUS_W-1:0]      mem_data_o,
  output logic                       mem_ready,
  output logic                       stall_req,
  output logic [SRAM_AW-1:0]         ram2_addr,
  inout  wire  [DATA_BUS_W-1:0]      ram2_data,
  output logic                       ram2_en_n,
  output logic                       ram2_oe_n,
  output logic                       ram2_we_n
);

  state_e                     state_q, state_d;
  src_e                       src_q, src_d;
  logic [DATA_ADDR_BUS_W-1:0] addr_q, addr_d;
  logic [DATA_BUS_W-1:0]      wdata_q, wdata_d;
  ram_ctl_t                   ctl_q, ctl_d;
  logic                       drive_q, drive_d;
  logic [INST_BUS_W-1:0]      inst_q, inst_d;
  logic [DATA_BUS_W-1:0]      mem_data_q, mem_data_d;
  logic                       if_ready_q, if_ready_d;
  logic                       mem_ready_q, mem_ready_d;

  logic mem_wr_c, mem_rd_c, if_go_c;

  // A request whose ready is pulsing this cycle is the one just finished, so it is not re-accepted.
  assign mem_wr_c = mem_ce & mem_we & ~mem_ready_q;
  assign mem_rd_c = mem_ce & mem_re & ~mem_we & ~mem_ready_q;
  assign if_go_c  = if_req & ~if_ready_q;

  // Next-state and next-output logic; MEM wins arbitration, write beats read.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ctl_d       = ctl_q;
    drive_d     = drive_q;
    inst_d      = inst_q;
    mem_data_d  = mem_data_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ctl_d   = RAM_CHIP_DISABLE;
        drive_d = 1'b0;
        if (mem_wr_c) begin
          state_d = ST_WR_SETUP;
          src_d   = SRC_MEM;
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          ctl_d   = RAM_WRITE_SETUP;
          drive_d = 1'b1;
        end else if (mem_rd_c) begin
          state_d = ST_RD_SETUP;
          src_d   = SRC_MEM;
          addr_d  = mem_addr_i;
          ctl_d   = RAM_READ_ENABLE;
        end else if (if_go_c) begin
          state_d = ST_RD_SETUP;
          src_d   = SRC_IF;
          addr_d  = pc;
          ctl_d   = RAM_READ_ENABLE;
        end
      end
      ST_RD_SETUP: begin
        state_d = ST_RD_SAMPLE;
      end
      ST_RD_SAMPLE: begin
        state_d = ST_IDLE;
        ctl_d   = RAM_CHIP_DISABLE;
        if (src_q == SRC_IF) begin
          inst_d     = ram2_data;
          if_ready_d = 1'b1;
        end else begin
          mem_data_d  = ram2_data;
          mem_ready_d = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        ctl_d   = RAM_WRITE_ENABLE;
      end
      ST_WR_PULSE: begin
        if (WR_HOLD_EN) begin
          state_d = ST_WR_HOLD;
          ctl_d   = RAM_WRITE_SETUP;
        end else begin
          state_d     = ST_IDLE;
          ctl_d       = RAM_CHIP_DISABLE;
          drive_d     = 1'b0;
          mem_ready_d = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        state_d     = ST_IDLE;
        ctl_d       = RAM_CHIP_DISABLE;
        drive_d     = 1'b0;
        mem_ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ctl_d   = RAM_CHIP_DISABLE;
        drive_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access and releases the bus at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      ctl_q       <= RAM_CHIP_DISABLE;
      drive_q     <= 1'b0;
      inst_q      <= NOP_INST;
      mem_data_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ctl_q       <= ctl_d;
      drive_q     <= drive_d;
      inst_q      <= inst_d;
      mem_data_q  <= mem_data_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Tri-state driver: the controller owns the bus only during write states.
  assign ram2_data = drive_q ? wdata_q : {DATA_BUS_W{1'bz}};

  assign ram2_addr  = SRAM_AW'(addr_q);
  assign ram2_en_n  = ctl_q.en_n;
  assign ram2_oe_n  = ctl_q.oe_n;
  assign ram2_we_n  = ctl_q.we_n;
  assign inst       = inst_q;
  assign mem_data_o = mem_data_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;

  // Stall while any valid request has not seen its ready pulse.
  assign stall_req = (if_req & ~if_ready_q) | (mem_ce & (mem_re | mem_we) & ~mem_ready_q);

endmodule

// File: tb/tb_ram2_ctrl.sv
// Scoreboard bench for ram2_ctrl with a behavioural async SRAM on the data bus.
module tb_ram2_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] pc = 16'h0;
  logic [15:0] inst;
  logic        if_ready;
  logic        mem_ce = 1'b0;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr_i = 16'h0;
  logic [15:0] mem_data_i = 16'h0;
  logic [15:0] mem_data_o;
  logic        mem_ready;
  logic        stall_req;
  logic [17:0] ram2_addr;
  wire  [15:0] ram2_data;
  logic        ram2_en_n;
  logic        ram2_oe_n;
  logic        ram2_we_n;

  always #5 clk = ~clk;

  ram2_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .pc        (pc),
    .inst      (inst),
    .if_ready  (if_ready),
    .mem_ce    (mem_ce),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o),
    .mem_ready (mem_ready),
    .stall_req (stall_req),
    .ram2_addr (ram2_addr),
    .ram2_data (ram2_data),
    .ram2_en_n (ram2_en_n),
    .ram2_oe_n (ram2_oe_n),
    .ram2_we_n (ram2_we_n)
  );

  // SRAM model: drives on en&oe, captures a write on a clock edge seen with en&we low.
  logic [15:0] sram [0:65535];
  logic        sram_loaded = 1'b0;

  assign ram2_data = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr[15:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_loaded) begin
      sram[16'h0004] <= 16'h6911;
      sram[16'h0010] <= 16'h1234;
      sram[16'h0020] <= 16'hABCD;
      sram[16'h0100] <= 16'h1111;
      sram_loaded    <= 1'b1;
    end else if (!ram2_en_n && !ram2_we_n) begin
      sram[ram2_addr[15:0]] <= ram2_data;
    end
  end

  typedef struct packed {
    logic        is_wr;
    logic [15:0] data;
  } mexp_t;

  logic [15:0] if_q[$];
  mexp_t       mem_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Monitor: bus sanity every cycle, pop and compare on each ready pulse.
  initial begin
    logic [15:0] last_rd;
    mexp_t       e;
    last_rd = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_rd = 16'h0;
      end else begin
        check("bus_oe_we", 32'(ram2_oe_n | ram2_we_n), 32'd1);
        check("addr_hi", 32'(ram2_addr[17:16]), 32'd0);
        if (if_ready) begin
          if (if_q.size() == 0) flag("if_ready_unexpected");
          else check("inst", 32'(inst), 32'(if_q.pop_front()));
        end
        if (mem_ready) begin
          if (mem_q.size() == 0) flag("mem_ready_unexpected");
          else begin
            e = mem_q.pop_front();
            if (e.is_wr) check("mem_data_hold", 32'(mem_data_o), 32'(last_rd));
            else begin
              check("mem_data_o", 32'(mem_data_o), 32'(e.data));
              last_rd = e.data;
            end
          end
        end
      end
    end
  end

  // Data access; called at a negedge, returns at the negedge of the ready pulse.
  task automatic mem_access(input logic we, input logic re, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_rd,
                            input int exp_lat, input string name);
    int cyc;
    int we_low;
    int oe_low;
    bit done;
    mem_q.push_back(mexp_t'({we, (we ? 16'h0 : exp_rd)}));
    mem_ce = 1'b1; mem_we = we; mem_re = re; mem_addr_i = addr; mem_data_i = wdata;
    cyc = 0; we_low = 0; oe_low = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({name, "_addr"}, 32'(ram2_addr), {14'd0, addr});
      if (!ram2_we_n) begin
        we_low++;
        check({name, "_wdata"}, 32'(ram2_data), 32'(wdata));
      end
      if (!ram2_oe_n) oe_low++;
      if (mem_ready) done = 1'b1;
      else check({name, "_stall"}, 32'(stall_req), 32'd1);
    end
    mem_ce = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    if (!done) flag({name, "_timeout"});
    else check({name, "_latency"}, 32'(cyc - 1), 32'(exp_lat));
    if (we) begin
      check({name, "_we_pulse"}, 32'(we_low), 32'd1);
      check({name, "_oe_quiet"}, 32'(oe_low), 32'd0);
    end
  endtask

  // Instruction fetch; called at a negedge, returns at the negedge of if_ready.
  task automatic if_fetch(input logic [15:0] addr, input logic [15:0] exp_inst,
                          input int exp_lat, input string name);
    int cyc;
    bit done;
    if_q.push_back(exp_inst);
    if_req = 1'b1; pc = addr;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (if_ready) done = 1'b1;
      else check({name, "_stall"}, 32'(stall_req), 32'd1);
    end
    if_req = 1'b0;
    if (!done) flag({name, "_timeout"});
    else check({name, "_latency"}, 32'(cyc - 1), 32'(exp_lat));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_en_n"}, 32'(ram2_en_n), 32'd1);
    check({name, "_oe_n"}, 32'(ram2_oe_n), 32'd1);
    check({name, "_we_n"}, 32'(ram2_we_n), 32'd1);
    check({name, "_addr"}, 32'(ram2_addr), 32'd0);
    check({name, "_inst"}, 32'(inst), 32'h0800);
    check({name, "_mem_data_o"}, 32'(mem_data_o), 32'd0);
    check({name, "_if_ready"}, 32'(if_ready), 32'd0);
    check({name, "_mem_ready"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin
    int cyc;
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);

    // Fetch pc=4 -> 6911
    if_fetch(16'h0004, 16'h6911, 2, "fetch4");
    @(negedge clk);

    // Write BEEF to 8000 then read back
    mem_access(1'b1, 1'b0, 16'h8000, 16'hBEEF, 16'h0, 3, "wr8000");
    @(negedge clk);
    mem_access(1'b0, 1'b1, 16'h8000, 16'h0, 16'hBEEF, 2, "rd8000");
    @(negedge clk);

    // re and we together: write wins
    mem_access(1'b1, 1'b1, 16'h0010, 16'h0055, 16'h0, 3, "wrrd0010");
    @(negedge clk);
    mem_access(1'b0, 1'b1, 16'h0010, 16'h0, 16'h0055, 2, "rd0010");
    @(negedge clk);

    // mem_ce with neither re nor we: no SRAM activity, no stall
    mem_ce = 1'b1; mem_addr_i = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nop_stall", 32'(stall_req), 32'd0);
      check("nop_en_n", 32'(ram2_en_n), 32'd1);
    end
    mem_ce = 1'b0;
    @(negedge clk);

    // Conflict: MEM read first, IF waits one idle cycle plus its 2-cycle read
    fork
      mem_access(1'b0, 1'b1, 16'h0020, 16'h0, 16'hABCD, 2, "conf_mem");
      if_fetch(16'h0004, 16'h6911, 5, "conf_if");
    join
    @(negedge clk);

    // Reset in the middle of the WE pulse aborts the write
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr_i = 16'h0100; mem_data_i = 16'h2222;
    cyc = 0;
    while (ram2_we_n && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (ram2_we_n) flag("abort_we_never_low");
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    mem_ce = 1'b0; mem_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_access(1'b0, 1'b1, 16'h0100, 16'h0, 16'h1111, 2, "rd0100");
    @(negedge clk);
    if_fetch(16'h8000, 16'hBEEF, 2, "fetch8000");

    repeat (3) @(negedge clk);
    check("if_q_empty", 32'(if_q.size()), 32'd0);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
